// File: rtl/tmds_encoder.sv
// One TMDS channel encoder: 8b/10b transition-minimised, DC-balanced symbols.
// Stage 1 picks XOR/XNOR coding, stage 2 balances disparity; optional retiming stage.
module tmds_encoder #(
  parameter int LATENCY = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       de_i,
  input  logic       c1_i,
  input  logic       c0_i,
  input  logic [7:0] d_i,
  output logic [9:0] q_o
);

  localparam logic [9:0] CTRL_00 = 10'h354;
  localparam logic [9:0] CTRL_01 = 10'h0AB;
  localparam logic [9:0] CTRL_10 = 10'h154;
  localparam logic [9:0] CTRL_11 = 10'h2AB;

  logic [3:0] n1_d;
  logic       xnor_path;
  logic [8:0] qm_d;
  logic [3:0] n1q_d;

  logic       de1;
  logic [1:0] ctl1;
  logic [8:0] qm1;
  logic [3:0] n1q;

  logic signed [5:0] cnt;
  logic signed [5:0] cnt_next;
  logic signed [5:0] diff;
  logic signed [5:0] qm8x2;
  logic signed [5:0] nqm8x2;
  logic [9:0]        q_next;
  logic [9:0]        q2;

  // Choose the coding that minimises transitions, then chain the bits.
  always_comb begin
    logic [8:0] t;
    n1_d = 4'd0;
    for (int i = 0; i < 8; i++) n1_d = n1_d + {3'b000, d_i[i]};
    xnor_path = (n1_d > 4'd4) || ((n1_d == 4'd4) && !d_i[0]);
    t = '0;
    t[0] = d_i[0];
    for (int i = 1; i < 8; i++) t[i] = xnor_path ? ~(t[i-1] ^ d_i[i]) : (t[i-1] ^ d_i[i]);
    t[8] = ~xnor_path;
    qm_d = t;
    n1q_d = 4'd0;
    for (int i = 0; i < 8; i++) n1q_d = n1q_d + {3'b000, t[i]};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      de1  <= 1'b0;
      ctl1 <= 2'b00;
      qm1  <= '0;
      n1q  <= '0;
    end else begin
      de1  <= de_i;
      ctl1 <= {c1_i, c0_i};
      qm1  <= qm_d;
      n1q  <= n1q_d;
    end
  end

  // diff is n1q - n0q; control periods restart the running disparity at zero.
  always_comb begin
    diff     = $signed({1'b0, n1q, 1'b0}) - 6'sd8;
    qm8x2    = $signed({4'b0000, qm1[8], 1'b0});
    nqm8x2   = $signed({4'b0000, ~qm1[8], 1'b0});
    q_next   = CTRL_00;
    cnt_next = 6'sd0;
    if (!de1) begin
      case (ctl1)
        2'b00:   q_next = CTRL_00;
        2'b01:   q_next = CTRL_01;
        2'b10:   q_next = CTRL_10;
        default: q_next = CTRL_11;
      endcase
    end else if ((cnt == 6'sd0) || (diff == 6'sd0)) begin
      q_next   = {~qm1[8], qm1[8], qm1[8] ? qm1[7:0] : ~qm1[7:0]};
      cnt_next = qm1[8] ? (cnt + diff) : (cnt - diff);
    end else if (((cnt > 6'sd0) && (diff > 6'sd0)) || ((cnt < 6'sd0) && (diff < 6'sd0))) begin
      q_next   = {1'b1, qm1[8], ~qm1[7:0]};
      cnt_next = cnt + qm8x2 - diff;
    end else begin
      q_next   = {1'b0, qm1[8], qm1[7:0]};
      cnt_next = cnt + diff - nqm8x2;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q2  <= CTRL_00;
      cnt <= 6'sd0;
    end else begin
      q2  <= q_next;
      cnt <= cnt_next;
    end
  end

  generate
    if (LATENCY == 3) begin : g_retime
      logic [9:0] q3;
      always_ff @(posedge clk_i) begin
        if (rst_i) q3 <= CTRL_00;
        else       q3 <= q2;
      end
      assign q_o = q3;
    end else begin : g_direct
      assign q_o = q2;
    end
  endgenerate

endmodule

// File: tb/tb_tmds_encoder.sv
// Self-checking bench for tmds_encoder at LATENCY 2 and 3 against a disparity model
// and a symbol decoder; directed steps followed by a random soak.
module tb_tmds_encoder;

  logic       clk;
  logic       rst;
  logic       de;
  logic       c1;
  logic       c0;
  logic [7:0] d;
  logic [9:0] q2;
  logic [9:0] q3;

  int errors = 0;
  int checks = 0;
  int mcnt   = 0;

  logic [9:0]  exp2[$];
  logic [9:0]  exp3[$];
  logic [10:0] src2[$];

  tmds_encoder #(.LATENCY(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .de_i(de), .c1_i(c1), .c0_i(c0), .d_i(d), .q_o(q2)
  );

  tmds_encoder #(.LATENCY(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .de_i(de), .c1_i(c1), .c0_i(c0), .d_i(d), .q_o(q3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] ctrlToken(input logic [1:0] c);
    case (c)
      2'b00:   return 10'h354;
      2'b01:   return 10'h0AB;
      2'b10:   return 10'h154;
      default: return 10'h2AB;
    endcase
  endfunction

  // Encoder reference: integer running disparity, ones-minus-zeros balance.
  task automatic modelStep(input logic r, input logic e, input logic [1:0] c,
                           input logic [7:0] x, output logic [9:0] sym);
    logic [7:0] qm;
    logic       qm8;
    int         ones;
    int         bal;
    if (r) begin
      mcnt = 0;
      sym  = 10'h354;
    end else if (!e) begin
      mcnt = 0;
      sym  = ctrlToken(c);
    end else begin
      ones  = $countones(x);
      qm8   = !((ones > 4) || (ones == 4 && x[0] == 1'b0));
      qm[0] = x[0];
      for (int i = 1; i < 8; i++) qm[i] = qm8 ? (qm[i-1] ^ x[i]) : ~(qm[i-1] ^ x[i]);
      bal = 2 * $countones(qm) - 8;
      if (mcnt == 0 || bal == 0) begin
        sym  = {~qm8, qm8, qm8 ? qm : ~qm};
        mcnt = mcnt + (qm8 ? bal : -bal);
      end else if ((mcnt > 0 && bal > 0) || (mcnt < 0 && bal < 0)) begin
        sym  = {1'b1, qm8, ~qm};
        mcnt = mcnt + 2 * int'(qm8) - bal;
      end else begin
        sym  = {1'b0, qm8, qm};
        mcnt = mcnt + bal - 2 * int'(!qm8);
      end
    end
  endtask

  // Receiver view of a symbol: {is_data, payload}.
  function automatic logic [10:0] decodeSym(input logic [9:0] s);
    logic [7:0] b;
    logic [7:0] x;
    if (s == 10'h354) return {1'b0, 8'h00, 2'b00};
    if (s == 10'h0AB) return {1'b0, 8'h00, 2'b01};
    if (s == 10'h154) return {1'b0, 8'h00, 2'b10};
    if (s == 10'h2AB) return {1'b0, 8'h00, 2'b11};
    b = s[9] ? ~s[7:0] : s[7:0];
    x[0] = b[0];
    for (int i = 1; i < 8; i++) x[i] = s[8] ? (b[i] ^ b[i-1]) : ~(b[i] ^ b[i-1]);
    return {1'b1, 2'b00, x};
  endfunction

  task automatic checkOutput(input string tag);
    logic [9:0]  e;
    logic [10:0] src;
    if (exp2.size() >= 2) begin
      e   = exp2.pop_front();
      src = src2.pop_front();
      checks++;
      assert (q2 === e) else begin
        errors++;
        $error("FAIL %s lat2 observed=%h expected=%h", tag, q2, e);
      end
      checks++;
      assert (decodeSym(q2) === src) else begin
        errors++;
        $error("FAIL %s decode observed=%h expected=%h", tag, decodeSym(q2), src);
      end
    end
    if (exp3.size() >= 3) begin
      e = exp3.pop_front();
      checks++;
      assert (q3 === e) else begin
        errors++;
        $error("FAIL %s lat3 observed=%h expected=%h", tag, q3, e);
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic [1:0] c,
                               input logic [7:0] x, input string tag);
    logic [9:0] sym;
    rst = r; de = e; c1 = c[1]; c0 = c[0]; d = x;
    @(posedge clk);
    #1;
    modelStep(r, e, c, x, sym);
    if (mcnt > 10 || mcnt < -10) $display("[TB] model disparity out of range: %0d", mcnt);
    if (r) begin
      exp2.delete(); exp3.delete(); src2.delete();
      exp2.push_back(10'h354);
      src2.push_back(11'h000);
      exp3.push_back(10'h354);
      exp3.push_back(10'h354);
    end
    exp2.push_back(sym);
    exp3.push_back(sym);
    src2.push_back((r || !e) ? {1'b0, 8'h00, (r ? 2'b00 : c)} : {1'b1, 2'b00, x});
    checkOutput(tag);
  endtask

  initial begin
    rst = 1'b1; de = 1'b1; c1 = 1'b0; c0 = 1'b0; d = 8'hFF;

    $display("[TB] reset with data applied");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 2'b00, 8'hFF, "reset");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 2'b00, 8'h00, "post_reset");

    $display("[TB] control tokens");
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 2'(i), 8'h00, "ctrl");

    $display("[TB] all-zeros data");
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 2'b00, 8'h00, "zeros");
    applyStimulus(1'b0, 1'b0, 2'b00, 8'h00, "ctrl_gap");

    $display("[TB] all-ones data and disparity restart");
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 2'b00, 8'hFF, "ones");
    applyStimulus(1'b0, 1'b0, 2'b00, 8'h00, "ones_ctrl");
    applyStimulus(1'b0, 1'b1, 2'b00, 8'hFF, "ones_restart");

    $display("[TB] de toggling every cycle");
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b0, i[0], 2'(i), 8'(8'h5A + i * 17), "toggle");

    $display("[TB] reset mid-stream");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 2'b00, 8'(8'h0F << i), "pre_mid");
    applyStimulus(1'b1, 1'b1, 2'b11, 8'hA5, "mid_reset");
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 2'b00, 8'hF0, "post_mid");

    $display("[TB] random soak");
    for (int i = 0; i < 4000; i++) begin
      logic       r;
      logic       e;
      logic [7:0] x;
      r = ($urandom_range(0, 299) == 0);
      e = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0:       x = 8'h00;
        1:       x = 8'hFF;
        default: x = 8'($urandom);
      endcase
      applyStimulus(r, e, 2'($urandom), x, "soak");
    end

    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 2'b00, 8'h00, "flush");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
